// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: PC sequencing, credit-limited request issue,
// in-order response buffering and redirect flush with in-flight response drop.
module fetch_queue_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] fetch_pc
);

    localparam int unsigned STEP  = DATA_W / 8;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(STEP - 1);
    localparam logic [CNT_W:0]    DEPTH_C    = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
    logic [DATA_W-1:0] instr_mem_q [DEPTH];

    logic credit_c, accept_c, rsp_c, write_c, pop_c;

    // Request issue: buffered plus in-flight entries may never exceed DEPTH
    assign credit_c  = ((CNT_W + 1)'(count_q) + (CNT_W + 1)'(outst_q)) < DEPTH_C;
    assign imem_req  = reset && !redirect_valid && credit_c;
    assign imem_addr = fetch_pc_q;
    assign fetch_pc  = fetch_pc_q;

    // Decode-side view of the FIFO head
    assign out_valid = (count_q != '0);
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign out_instr = instr_mem_q[rd_ptr_q];

    // Next-state: handshakes, response accounting and redirect flush
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        accept_c = imem_req && imem_gnt;
        rsp_c    = imem_rvalid && (outst_q != '0);
        pop_c    = (count_q != '0) && out_ready;
        write_c  = rsp_c && (drop_q == '0) && !redirect_valid;

        if (accept_c) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
        if (write_c) begin
            rsp_pc_d = rsp_pc_q + PC_STEP;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (rsp_c && (drop_q != '0)) begin
            drop_d = drop_q - CNT_W'(1);
        end
        count_d = count_q + CNT_W'(write_c) - CNT_W'(pop_c);
        outst_d = outst_q + CNT_W'(accept_c) - CNT_W'(rsp_c);

        // Redirect: flush buffer, drop every request still in flight, restart PC
        if (redirect_valid) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            drop_d     = outst_d;
            fetch_pc_d = redirect_pc & ALIGN_MASK;
            rsp_pc_d   = redirect_pc & ALIGN_MASK;
        end
    end

    // State and FIFO storage registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            if (write_c) begin
                pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
                instr_mem_q[wr_ptr_q] <= imem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: queue-based reference model, in-order memory
// model with random latency, directed scenarios plus a random stream.
module tb_fetch_queue_unit;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] fetch_pc;

    always #5 clk = ~clk;

    fetch_queue_unit #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(RESET_PC), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .fetch_pc(fetch_pc)
    );

    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct { logic [31:0] addr; bit drop; } infl_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat_min = 1;
    int lat_max = 1;
    int last_due = 0;
    logic [31:0] key = 32'h0;
    bit stale_inject = 0;

    // reference model: buffered entries, in-flight requests, next fetch address
    ent_t  fq[$];
    infl_t inf[$];
    logic [31:0] m_fpc = RESET_PC;

    pend_t pend[$];
    logic [31:0] dpc[$];
    logic [31:0] dins[$];
    int          dcyc[$];
    logic [31:0] gaddr[$];
    int          gcyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        dpc.delete(); dins.delete(); dcyc.delete(); gaddr.delete(); gcyc.delete();
    endtask

    // One clock cycle: memory drives response, compare at negedge, model updates at posedge
    task automatic tick();
        logic c_rst, c_redir, c_ready, c_gnt, c_rv;
        logic [31:0] c_rpc, c_rd;
        bit served, e_req;
        int d;
        infl_t e;
        ent_t n;
        served = 0;
        if (stale_inject && reset) begin
            imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; stale_inject = 0;
        end else if (pend.size() != 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1; imem_rdata = pend[0].addr ^ key; served = 1;
        end else begin
            imem_rvalid = 1'b0; imem_rdata = $urandom;
        end
        #4;
        c_rst = reset; c_redir = redirect_valid; c_rpc = redirect_pc;
        c_ready = out_ready; c_gnt = imem_gnt; c_rv = imem_rvalid; c_rd = imem_rdata;

        e_req = c_rst && !c_redir && ((fq.size() + inf.size()) < DEPTH);
        check("imem_req", 32'(imem_req), 32'(e_req));
        if (e_req) check("imem_addr", imem_addr, m_fpc);
        check("fetch_pc", fetch_pc, m_fpc);
        check("out_valid", 32'(out_valid), 32'(fq.size() != 0));
        if (fq.size() != 0) begin
            check("out_pc", out_pc, fq[0].pc);
            check("out_instr", out_instr, fq[0].instr);
        end

        if (c_rst && out_valid && c_ready) begin
            dpc.push_back(out_pc); dins.push_back(out_instr); dcyc.push_back(cyc);
        end
        if (!c_rst) begin
            pend.delete(); last_due = 0;
        end else begin
            if (served) void'(pend.pop_front());
            if (imem_req && c_gnt) begin
                gaddr.push_back(imem_addr); gcyc.push_back(cyc);
                d = cyc + int'($urandom_range(lat_max, lat_min));
                if (d < last_due) d = last_due;
                last_due = d;
                pend.push_back('{addr: imem_addr, due: d});
            end
        end

        @(posedge clk);
        if (!c_rst) begin
            fq.delete(); inf.delete(); m_fpc = RESET_PC;
        end else begin
            if (fq.size() != 0 && c_ready) void'(fq.pop_front());
            if (c_rv && inf.size() != 0) begin
                e = inf.pop_front();
                if (!e.drop && !c_redir) begin
                    n.pc = e.addr; n.instr = c_rd;
                    fq.push_back(n);
                end
            end
            if (e_req && c_gnt) begin
                e.addr = m_fpc; e.drop = 0;
                inf.push_back(e);
                m_fpc = m_fpc + 32'd4;
            end
            if (c_redir) begin
                fq.delete();
                foreach (inf[i]) inf[i].drop = 1;
                m_fpc = c_rpc & ~32'h3;
            end
        end
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0; redirect_valid = 1'b0;
        repeat (n) tick();
        reset = 1'b1;
    endtask

    initial begin
        int r;
        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_imem_req", 32'(imem_req), 32'h0);

        // Streaming after reset release, 1-cycle memory, data = address
        key = 0; lat_min = 1; lat_max = 1; imem_gnt = 1; out_ready = 1;
        do_reset(2);
        r = cyc; clear_logs();
        run(8);
        check("t1_first_req_cyc", 32'(gcyc[0]), 32'(r));
        check("t1_first_req_addr", gaddr[0], RESET_PC);
        check("t1_first_valid_cyc", 32'(dcyc[0]), 32'(r + 2));
        check("t1_pc0", dpc[0], 32'h0);
        check("t1_pc1", dpc[1], 32'h4);
        check("t1_pc2", dpc[2], 32'h8);
        check("t1_pc3", dpc[3], 32'hC);
        check("t1_instr1", dins[1], 32'h4);
        check("t1_pc3_cyc", 32'(dcyc[3]), 32'(r + 5));

        // Decode stalled: credit limit caps requests at DEPTH
        do_reset(1); out_ready = 0; clear_logs();
        run(10);
        check("t2_req_count", 32'(gaddr.size()), 32'(DEPTH));
        out_ready = 1;
        run(8);
        check("t2_pc0", dpc[0], 32'h0);
        check("t2_pc1", dpc[1], 32'h4);
        check("t2_pc2", dpc[2], 32'h8);
        check("t2_pc3", dpc[3], 32'hC);
        check("t2_next_req", gaddr[4], 32'h10);

        // Grant withheld: address held
        do_reset(1); out_ready = 1; clear_logs();
        run(2);
        imem_gnt = 0;
        repeat (3) begin
            tick();
            check("t3_addr_hold", imem_addr, 32'h8);
            check("t3_fetch_pc_hold", fetch_pc, 32'h8);
        end
        imem_gnt = 1;
        run(8);
        for (int i = 0; i < 5; i++) begin
            check("t3_pc_seq", dpc[i], 32'(4 * i));
            check("t3_req_seq", gaddr[i], 32'(4 * i));
        end

        // Redirect with entries buffered and requests in flight
        do_reset(1); out_ready = 0; lat_min = 3; lat_max = 3; clear_logs();
        run(5);
        redirect_valid = 1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 0;
        check("t4_flush_valid", 32'(out_valid), 32'h0);
        check("t4_new_fetch", imem_addr, 32'h100);
        out_ready = 1; clear_logs();
        run(12);
        check("t4_pc0", dpc[0], 32'h100);
        check("t4_instr0", dins[0], 32'h100);
        check("t4_pc1", dpc[1], 32'h104);

        // Redirect near top of address space and to an unaligned target
        lat_min = 1; lat_max = 1;
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 0; clear_logs();
        run(10);
        check("t5_wrap0", dpc[0], 32'hFFFF_FFF8);
        check("t5_wrap1", dpc[1], 32'hFFFF_FFFC);
        check("t5_wrap2", dpc[2], 32'h0000_0000);
        redirect_valid = 1; redirect_pc = 32'h103;
        tick();
        redirect_valid = 0;
        check("t5_align", fetch_pc, 32'h100);
        run(4);

        // Reset mid-stream with responses in flight, stale rvalid afterwards
        lat_min = 2; lat_max = 3;
        run(6);
        reset = 0;
        tick();
        reset = 1; stale_inject = 1;
        check("t6_valid_after_rst", 32'(out_valid), 32'h0);
        clear_logs();
        run(10);
        check("t6_pc0", dpc[0], RESET_PC);
        check("t6_instr0", dins[0], RESET_PC);

        // Random stream
        lat_min = 1; lat_max = 4; key = $urandom;
        for (int i = 0; i < 3000; i++) begin
            out_ready = ($urandom_range(3, 0) != 0);
            imem_gnt = ($urandom_range(3, 0) != 0);
            redirect_valid = ($urandom_range(24, 0) == 0);
            redirect_pc = $urandom;
            if ($urandom_range(99, 0) == 0) begin
                reset = 0;
                tick();
                reset = 1; stale_inject = 1;
            end else begin
                tick();
            end
        end
        redirect_valid = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
